// File: rtl/vc_stall_skid_buf.sv
// Stall-to-handshake skid buffer: terminates a stall-controlled pipeline and
// re-issues its signed samples on a valid/ready port through a circular FIFO.
//
// Ports:
//   clk, n_rst       clock (rising edge), async active-low reset
//   flush            synchronous clear of buffer contents (beats push/pop)
//   in_valid/in_data upstream last-stage sample and its valid
//   stall            registered freeze request, high exactly while full
//   out_valid/ready  downstream handshake; out_data is the registered head
//   level            occupancy, only when VC_SKID_LEVEL_EN is defined
//
// Build option: define VC_SKID_LEVEL_EN to expose the level port.
module vc_stall_skid_buf #(
    parameter  int DWIDTH = 24,
    parameter  int DEPTH  = 4,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(DEPTH + 1)
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     flush,
    input  logic                     in_valid,
    input  logic signed [DWIDTH-1:0] in_data,
    output logic                     stall,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic signed [DWIDTH-1:0] out_data
`ifdef VC_SKID_LEVEL_EN
    ,
    output logic [CW-1:0]            level
`endif
);

    localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
    localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

    logic [DWIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]     count_q,  count_d;
    logic              stall_q,  stall_d;
    logic              valid_q,  valid_d;
    logic [DWIDTH-1:0] data_q,   data_d;

    logic              push;
    logic              pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == PTR_LAST) ? '0 : p + AW'(1);
    endfunction

    always_comb begin
        push     = in_valid & ~stall_q;
        pop      = valid_q & out_ready;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        data_d   = data_q;

        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
            data_d   = '0;
        end else begin
            if (push) begin
                wr_ptr_d = ptr_inc(wr_ptr_q);
            end
            if (pop) begin
                rd_ptr_d = ptr_inc(rd_ptr_q);
            end

            unique case ({push, pop})
                2'b10:   count_d = count_q + CW'(1);
                2'b01:   count_d = count_q - CW'(1);
                default: count_d = count_q;
            endcase

            // The new head is the word being written when the buffer is
            // (or becomes) empty this cycle, so forward it from the input.
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                data_d = in_data;
            end else if (pop) begin
                data_d = mem_q[rd_ptr_d];
            end
        end

        stall_d = (count_d == CNT_FULL);
        valid_d = (count_d != '0);
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            stall_q  <= 1'b0;
            valid_q  <= 1'b0;
            data_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            stall_q  <= stall_d;
            valid_q  <= valid_d;
            data_q   <= data_d;
        end
    end

    // Storage needs no reset; occupancy alone decides what is valid.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem_q[wr_ptr_q] <= in_data;
        end
    end

    assign stall     = stall_q;
    assign out_valid = valid_q;
    assign out_data  = data_q;

`ifdef VC_SKID_LEVEL_EN
    assign level = count_q;
`endif

endmodule
